// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared constants and types for the timer peripheral.
//   TIM_WIDTH    : default datapath width of prescaler, counter, PSC and ARR
//   TIM_PSC_RST  : default reset value of the PSC preload/active registers
//   TIM_ARR_RST  : default reset value of the ARR preload/active registers
//   tim_state_t  : timer control FSM states
// -----------------------------------------------------------------------------
package timer_pkg;

  localparam int unsigned TIM_WIDTH   = 16;
  localparam logic [15:0] TIM_PSC_RST = 16'h0000;
  localparam logic [15:0] TIM_ARR_RST = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tim_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
// Divides the clock by (psc_act_i + 1) while running and emits a one-cycle
// tick on the cycle the prescale count matches psc_act_i.
// Ports:
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   psc_act_i : active prescaler value
//   run_i     : count this cycle
//   clear_i   : force the prescale count to zero (wins over run_i)
//   tick_o    : combinational tick, high on the wrap cycle
// -----------------------------------------------------------------------------
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = TIM_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] psc_act_i,
  input  logic             run_i,
  input  logic             clear_i,
  output logic             tick_o
);

  logic [WIDTH-1:0] psc_cnt_q;
  logic [WIDTH-1:0] psc_cnt_d;

  // A clear suppresses the tick so a forced update never doubles up with a
  // natural counter advance in the same cycle.
  assign tick_o = run_i && !clear_i && (psc_cnt_q == psc_act_i);

  always_comb begin
    psc_cnt_d = psc_cnt_q;
    if (clear_i) begin
      psc_cnt_d = '0;
    end else if (run_i) begin
      psc_cnt_d = tick_o ? '0 : psc_cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      psc_cnt_q <= '0;
    end else begin
      psc_cnt_q <= psc_cnt_d;
    end
  end

endmodule

// File: rtl/timer_unit.sv
// -----------------------------------------------------------------------------
// timer_unit
// Prescaled up-counter with auto-reload, PSC/ARR preload shadows, a sticky
// update flag and an interrupt request.
// Ports:
//   clk, reset     : system clock, asynchronous active-low reset
//   TIM_PSC/psc_wr : prescaler preload value and its write strobe
//   TIM_ARR/arr_wr : auto-reload preload value and its write strobe
//   cen            : counter enable (level)
//   opm            : one-pulse mode, latched when leaving IDLE
//   ug             : software forced update (ignored in DONE)
//   uie            : update interrupt enable
//   uif_clr        : clear the sticky update flag
//   cnt            : current counter value
//   uev            : registered one-cycle update-event pulse
//   uif            : sticky update flag
//   irq            : uif & uie
//   running        : FSM is in RUN
//   dbg_state_o    : current FSM state for observation
// Write strobes carry no handshake: a strobe high on a rising edge captures
// its data into the preload register on that edge, unconditionally.
// -----------------------------------------------------------------------------
module timer_unit
  import timer_pkg::*;
#(
  parameter int unsigned      WIDTH   = TIM_WIDTH,
  parameter logic [WIDTH-1:0] PSC_RST = WIDTH'(TIM_PSC_RST),
  parameter logic [WIDTH-1:0] ARR_RST = WIDTH'(TIM_ARR_RST)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] TIM_PSC,
  input  logic [WIDTH-1:0] TIM_ARR,
  input  logic             psc_wr,
  input  logic             arr_wr,
  input  logic             cen,
  input  logic             opm,
  input  logic             ug,
  input  logic             uie,
  input  logic             uif_clr,
  output logic [WIDTH-1:0] cnt,
  output logic             uev,
  output logic             uif,
  output logic             irq,
  output logic             running,
  output tim_state_t       dbg_state_o
);

  tim_state_t       state_q, state_d;
  logic             opm_q, opm_d;
  logic [WIDTH-1:0] psc_pre_q, psc_pre_d;
  logic [WIDTH-1:0] arr_pre_q, arr_pre_d;
  logic [WIDTH-1:0] psc_act_q, psc_act_d;
  logic [WIDTH-1:0] arr_act_q, arr_act_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             uev_q, uev_d;
  logic             uif_q, uif_d;

  logic run;
  logic tick;
  logic ug_evt;
  logic ovf;
  logic evt;
  logic psc_clear;

  // Counting only happens in RUN with the enable still high; the cycle in
  // which cen falls is the pause cycle and does not advance anything.
  assign run       = (state_q == RUN) && cen;
  assign ug_evt    = ug && (state_q != DONE);
  assign psc_clear = ug_evt || (state_q == DONE);

  timer_prescaler #(
    .WIDTH (WIDTH)
  ) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .psc_act_i (psc_act_q),
    .run_i     (run),
    .clear_i   (psc_clear),
    .tick_o    (tick)
  );

  // >= rather than == so a counter left above a lowered ARR still wraps.
  assign ovf = tick && (cnt_q >= arr_act_q);
  assign evt = ovf || ug_evt;

  // FSM next state
  always_comb begin
    state_d = state_q;
    opm_d   = opm_q;
    unique case (state_q)
      IDLE: begin
        if (cen) begin
          state_d = RUN;
          opm_d   = opm;
        end
      end
      RUN: begin
        if (!cen) begin
          state_d = IDLE;
        end else if (evt && opm_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!cen) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter, shadows and flags
  always_comb begin
    psc_pre_d = psc_wr ? TIM_PSC : psc_pre_q;
    arr_pre_d = arr_wr ? TIM_ARR : arr_pre_q;

    // Active registers take the pre-write preload, so a write landing on an
    // event edge only takes effect at the following event.
    psc_act_d = psc_act_q;
    arr_act_d = arr_act_q;
    if (evt || (state_q == IDLE)) begin
      psc_act_d = psc_pre_q;
      arr_act_d = arr_pre_q;
    end

    cnt_d = cnt_q;
    if ((state_q == DONE) || ug_evt) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = ovf ? '0 : cnt_q + WIDTH'(1);
    end

    uev_d = evt;

    // Set has priority over clear.
    uif_d = uif_q;
    if (evt) begin
      uif_d = 1'b1;
    end else if (uif_clr) begin
      uif_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      opm_q     <= 1'b0;
      psc_pre_q <= PSC_RST;
      arr_pre_q <= ARR_RST;
      psc_act_q <= PSC_RST;
      arr_act_q <= ARR_RST;
      cnt_q     <= '0;
      uev_q     <= 1'b0;
      uif_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      opm_q     <= opm_d;
      psc_pre_q <= psc_pre_d;
      arr_pre_q <= arr_pre_d;
      psc_act_q <= psc_act_d;
      arr_act_q <= arr_act_d;
      cnt_q     <= cnt_d;
      uev_q     <= uev_d;
      uif_q     <= uif_d;
    end
  end

  assign cnt         = cnt_q;
  assign uev         = uev_q;
  assign uif         = uif_q;
  assign irq         = uif_q & uie;
  assign running     = (state_q == RUN);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_timer_unit.sv
// -----------------------------------------------------------------------------
// tb_timer_unit
// Directed scenarios followed by randomized segments checked against a
// period-level reference model of the timer.
// -----------------------------------------------------------------------------
module tb_timer_unit;
  import timer_pkg::*;

  localparam int W = 16;

  // ---------------------------------------------------------------- clock/reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] TIM_PSC = '0;
  logic [W-1:0] TIM_ARR = '0;
  logic psc_wr = 0, arr_wr = 0, cen = 0, opm = 0, ug = 0, uie = 0, uif_clr = 0;
  logic [W-1:0] cnt;
  logic uev, uif, irq, running;
  tim_state_t dbg_state;

  timer_unit dut (
    .clk         (clk),
    .reset       (reset),
    .TIM_PSC     (TIM_PSC),
    .TIM_ARR     (TIM_ARR),
    .psc_wr      (psc_wr),
    .arr_wr      (arr_wr),
    .cen         (cen),
    .opm         (opm),
    .ug          (ug),
    .uie         (uie),
    .uif_clr     (uif_clr),
    .cnt         (cnt),
    .uev         (uev),
    .uif         (uif),
    .irq         (irq),
    .running     (running),
    .dbg_state_o (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // ---------------------------------------------------------------- reference model
  // Position-in-period model: m_p counts enabled RUN cycles since the last
  // update; the period is (psc+1)*(arr+1) and cnt is m_p/(psc+1).
  // m_mode: 0 idle, 1 running, 2 one-pulse finished.
  bit model_on = 0;
  int m_mode, m_p, m_psc, m_arr;
  bit m_opm, m_uev, m_uif;

  task automatic model_reset();
    m_mode = 0; m_p = 0; m_opm = 0; m_uev = 0; m_uif = 0;
  endtask

  task automatic model_eval();
    int per;
    bit ev;
    per = (m_psc + 1) * (m_arr + 1);
    ev  = 0;
    if (m_mode == 2) begin
      if (!cen) m_mode = 0;
    end else if (m_mode == 0) begin
      if (ug) begin m_p = 0; ev = 1; end
      if (cen) begin m_mode = 1; m_opm = opm; end
    end else begin
      if (ug) begin
        m_p = 0; ev = 1;
      end else if (cen) begin
        if (m_p + 1 == per) begin m_p = 0; ev = 1; end
        else m_p++;
      end
      if (!cen) m_mode = 0;
      else if (ev && m_opm) m_mode = 2;
    end
    m_uev = ev;
    m_uif = ev ? 1'b1 : (uif_clr ? 1'b0 : m_uif);
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic step();
    int exp_cnt;
    if (model_on) model_eval();
    @(posedge clk); #1;
    psc_wr = 0; arr_wr = 0; ug = 0; uif_clr = 0;
    if (model_on) begin
      exp_cnt = (m_mode == 2) ? 0 : m_p / (m_psc + 1);
      chk("rnd_cnt", 32'(cnt), 32'(exp_cnt));
      chk("rnd_uev", 32'(uev), 32'(m_uev));
      chk("rnd_uif", 32'(uif), 32'(m_uif));
      chk("rnd_irq", 32'(irq), 32'(m_uif & uie));
      chk("rnd_running", 32'(running), 32'(m_mode == 1));
    end
  endtask

  // Steps until uev is seen (bounded) and checks the number of cycles taken.
  task automatic wait_uev(input string tag, input int exp);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (uev !== 1'b1 && n < 64);
    chk(tag, 32'(n), 32'(exp));
  endtask

  task automatic write_cfg(input int psc, input int arr);
    TIM_PSC = W'(psc); TIM_ARR = W'(arr);
    psc_wr = 1; arr_wr = 1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int psc, arr;

    // Reset state
    #1 reset = 0;
    #1;
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_uev", 32'(uev), 0);
    chk("rst_uif", 32'(uif), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_running", 32'(running), 0);
    @(negedge clk) reset = 1;

    // PSC=2, ARR=3: 12-cycle period, cnt 0,0,0,1,1,1,2,2,2,3,3,3,0
    write_cfg(2, 3); step();
    step();
    cen = 1; step();
    chk("t1_run", 32'(running), 1);
    chk("t1_cnt0", 32'(cnt), 0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t1_cnt", 32'(cnt), (k == 12) ? 0 : k / 3);
      chk("t1_uev", 32'(uev), 32'(k == 12));
      chk("t1_uif", 32'(uif), 32'(k == 12));
      chk("t1_irq_off", 32'(irq), 0);
    end
    uie = 1; #1;
    chk("t1_irq_on", 32'(irq), 1);
    wait_uev("t1_period2", 12);
    uif_clr = 1; step();
    chk("t1_uif_clr", 32'(uif), 0);
    chk("t1_irq_clr", 32'(irq), 0);
    repeat (10) step();
    uif_clr = 1; step();
    chk("clr_vs_set_uev", 32'(uev), 1);
    chk("clr_vs_set_uif", 32'(uif), 1);
    uie = 0;

    // PSC=0, ARR=4, ARR lowered to 1 mid-period
    cen = 0; ug = 1; write_cfg(0, 4); step();
    step();
    cen = 1; step();
    step(); step();
    TIM_ARR = W'(1); arr_wr = 1; step();
    wait_uev("t2_cur_period", 2);
    wait_uev("t2_next_period", 2);
    wait_uev("t2_next_period2", 2);

    // PSC=0, ARR=2, ARR=7 written on the event cycle
    TIM_ARR = W'(2); arr_wr = 1; step();
    wait_uev("t3_load2", 1);
    step(); step();
    TIM_ARR = W'(7); arr_wr = 1; step();
    chk("t3_evt_uev", 32'(uev), 1);
    chk("t3_evt_cnt", 32'(cnt), 0);
    wait_uev("t3_period_old", 3);
    wait_uev("t3_period_new", 8);

    // One-pulse mode, PSC=0, ARR=3
    cen = 0; ug = 1; write_cfg(0, 3); step();
    step();
    opm = 1; cen = 1; step();
    wait_uev("t4_pulse", 4);
    chk("t4_stopped", 32'(running), 0);
    chk("t4_cnt", 32'(cnt), 0);
    repeat (3) begin
      step();
      chk("t4_hold_cnt", 32'(cnt), 0);
      chk("t4_hold_uev", 32'(uev), 0);
    end
    ug = 1; step();
    chk("t4_ug_done_ignored", 32'(uev), 0);
    cen = 0; step();
    cen = 1; step();
    chk("t4_restart", 32'(running), 1);
    wait_uev("t4_pulse2", 4);
    chk("t4_stopped2", 32'(running), 0);
    cen = 0; opm = 0; step();

    // Pause at cnt=5 with ARR=9
    TIM_ARR = W'(9); arr_wr = 1; step();
    step();
    cen = 1; step();
    repeat (5) step();
    chk("t5_cnt5", 32'(cnt), 5);
    cen = 0;
    repeat (10) begin
      step();
      chk("t5_pause_cnt", 32'(cnt), 5);
      chk("t5_pause_run", 32'(running), 0);
    end
    cen = 1; step();
    chk("t5_resume_cnt", 32'(cnt), 5);
    wait_uev("t5_resume_evt", 5);

    // ug at cnt=6
    repeat (6) step();
    chk("t6_cnt6", 32'(cnt), 6);
    ug = 1; step();
    chk("t6_ug_cnt", 32'(cnt), 0);
    chk("t6_ug_uev", 32'(uev), 1);
    wait_uev("t6_period", 10);

    // Reset mid-run while uev is high
    repeat (3) step();
    ug = 1; step();
    #1 reset = 0;
    #1;
    chk("t7_cnt", 32'(cnt), 0);
    chk("t7_uev", 32'(uev), 0);
    chk("t7_uif", 32'(uif), 0);
    chk("t7_irq", 32'(irq), 0);
    chk("t7_running", 32'(running), 0);
    @(negedge clk) reset = 1;
    step();
    repeat (3) step();
    chk("t7_psc_rst", 32'(cnt), 3);

    // Randomized segments against the reference model
    @(negedge clk) reset = 0; cen = 0; opm = 0; uie = 0;
    #1 reset = 1;
    model_reset();
    m_psc = 0; m_arr = 32'hFFFF;
    model_on = 1;
    for (int seg = 0; seg < 12; seg++) begin
      psc = (seg == 1) ? 0 : int'($urandom_range(0, 3));
      arr = (seg == 0) ? 0 : int'($urandom_range(0, 7));
      cen = 0; uif_clr = 0; ug = 1; step();
      write_cfg(psc, arr); step();
      step();
      m_psc = psc; m_arr = arr;
      for (int c = 0; c < 150; c++) begin
        cen     = ($urandom_range(0, 15) != 0);
        ug      = ($urandom_range(0, 40) == 0);
        uif_clr = ($urandom_range(0, 5) == 0);
        uie     = ($urandom_range(0, 1) == 1);
        opm     = ($urandom_range(0, 3) == 0);
        step();
      end
    end
    model_on = 0;

    // ---------------------------------------------------------------- report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
